display_scan_decoder: RTL and testbench

DISPLAY_SCAN_DECODER -- requirements
Module: display_scan_decoder

---
 rtl/display_scan_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_display_scan_decoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_decoder.sv
// Recovers HH:MM:SS from a multiplexed, active-low 7-segment scan bus.
// Ports: clk, reset (async, low); scan_en/scan_seg (scan bus), clr_err;
//        o_hour/o_min/o_sec + o_valid strobe; sticky o_err_pat/range/scan.
module display_scan_decoder #(
  parameter int unsigned SETTLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scan_en,
  input  logic [7:0] scan_seg,
  input  logic       clr_err,
  output logic [5:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic       o_valid,
  output logic       o_err_pat,
  output logic       o_err_range,
  output logic       o_err_scan
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPT
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       en_q, en_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       idx_q, idx_d;
  logic [5:0]       mask_q, mask_d;
  logic [5:0][3:0]  dig_q, dig_d;
  logic [5:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic             valid_q, valid_d;
  logic             epat_q, epat_d;
  logic             erng_q, erng_d;
  logic             escan_q, escan_d;

  logic [3:0] nlow;
  logic       multi_low;
  logic [3:0] cur;
  logic       cur_ok;
  logic [4:0] dec;
  logic       cap;
  logic       pat_ev;
  logic       rng_ev;
  logic       complete;
  logic [5:0] mk;
  logic [6:0] h7, m7, s7;

  // {ok, digit index}; only a lone low on bits 0..5 is a digit.
  function automatic logic [3:0] map_en(input logic [7:0] en);
    logic [3:0] r;
    case (en)
      8'hFE:   r = 4'b1_000;
      8'hFD:   r = 4'b1_001;
      8'hFB:   r = 4'b1_010;
      8'hF7:   r = 4'b1_011;
      8'hEF:   r = 4'b1_100;
      8'hDF:   r = 4'b1_101;
      default: r = 4'b0_000;
    endcase
    return r;
  endfunction

  // {ok, value}; dp is not part of the pattern.
  function automatic logic [4:0] dec_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h40:   r = 5'h10;
      7'h79:   r = 5'h11;
      7'h24:   r = 5'h12;
      7'h30:   r = 5'h13;
      7'h19:   r = 5'h14;
      7'h12:   r = 5'h15;
      7'h02:   r = 5'h16;
      7'h78:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h10:   r = 5'h19;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  always_comb begin
    nlow = '0;
    for (int i = 0; i < 8; i++) begin
      nlow = nlow + {3'b000, ~scan_en[i]};
    end
  end

  assign multi_low = (nlow > 4'd1);
  assign cur       = map_en(scan_en);
  assign cur_ok    = cur[3];
  assign dec       = dec_seg(seg_q[6:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    seg_d   = seg_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cur_ok) begin
          state_d = S_SETTLE;
          en_d    = scan_en;
          seg_d   = scan_seg;
          idx_d   = cur[2:0];
          cnt_d   = 8'd1;
        end
      end
      S_SETTLE: begin
        if (scan_en == en_q && scan_seg == seg_q) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == 8'(SETTLE)) begin
            cap     = 1'b1;
            state_d = S_CAPT;
          end
        end else if (cur_ok) begin
          en_d  = scan_en;
          seg_d = scan_seg;
          idx_d = cur[2:0];
          cnt_d = 8'd1;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_CAPT: begin
        // Segment changes within the same dwell are ignored.
        if (scan_en != en_q) begin
          if (cur_ok) begin
            state_d = S_SETTLE;
            en_d    = scan_en;
            seg_d   = scan_seg;
            idx_d   = cur[2:0];
            cnt_d   = 8'd1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    dig_d    = dig_q;
    mask_d   = mask_q;
    mk       = mask_q;
    complete = 1'b0;
    pat_ev   = 1'b0;
    rng_ev   = 1'b0;
    valid_d  = 1'b0;
    hour_d   = hour_q;
    min_d    = min_q;
    sec_d    = sec_q;
    if (cap) begin
      if (!dec[4]) begin
        pat_ev = 1'b1;
      end else begin
        dig_d[idx_q] = dec[3:0];
        // Digit 0 opens a frame, so it restarts the mask.
        mk = (idx_q == 3'd0) ? 6'b000001
                             : (mask_q | (6'b000001 << idx_q));
        complete = (mk == 6'h3F);
        mask_d   = complete ? 6'h00 : mk;
      end
    end
    h7 = 7'(dig_d[5]) * 7'd10 + 7'(dig_d[4]);
    m7 = 7'(dig_d[3]) * 7'd10 + 7'(dig_d[2]);
    s7 = 7'(dig_d[1]) * 7'd10 + 7'(dig_d[0]);
    if (complete) begin
      if (h7 <= 7'd23 && m7 <= 7'd59 && s7 <= 7'd59) begin
        valid_d = 1'b1;
        hour_d  = h7[5:0];
        min_d   = m7[5:0];
        sec_d   = s7[5:0];
      end else begin
        rng_ev = 1'b1;
      end
    end
  end

  // An error event in the clearing cycle keeps its flag set.
  assign epat_d  = (epat_q & ~clr_err) | pat_ev;
  assign erng_d  = (erng_q & ~clr_err) | rng_ev;
  assign escan_d = (escan_q & ~clr_err) | multi_low;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      idx_q   <= '0;
      mask_q  <= '0;
      dig_q   <= '0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      valid_q <= 1'b0;
      epat_q  <= 1'b0;
      erng_q  <= 1'b0;
      escan_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      seg_q   <= seg_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      dig_q   <= dig_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      valid_q <= valid_d;
      epat_q  <= epat_d;
      erng_q  <= erng_d;
      escan_q <= escan_d;
    end
  end

  assign o_hour      = hour_q;
  assign o_min       = min_q;
  assign o_sec       = sec_q;
  assign o_valid     = valid_q;
  assign o_err_pat   = epat_q;
  assign o_err_range = erng_q;
  assign o_err_scan  = escan_q;

endmodule

// File: tb/tb_display_scan_decoder.sv
// Scoreboard bench for display_scan_decoder: directed scan frames.
// Expected times queued at digit-5 start; monitor checks each o_valid.
module tb_display_scan_decoder;

  localparam int SETTLE = 16;
  localparam int DW     = 1000;
  localparam int DS     = 300;

  localparam logic [7:0] P0 = 8'hC0, P1 = 8'hF9, P2 = 8'hA4;
  localparam logic [7:0] P3 = 8'hB0, P4 = 8'h99, P5 = 8'h92;
  localparam logic [7:0] P6 = 8'h82, P7 = 8'hF8, P8 = 8'h80;
  localparam logic [7:0] P9 = 8'h90;

  localparam logic [7:0] ENS [6] = '{8'hFE, 8'hFD, 8'hFB,
                                     8'hF7, 8'hEF, 8'hDF};

  logic       clk;
  logic       reset;
  logic [7:0] scan_en;
  logic [7:0] scan_seg;
  logic       clr_err;
  logic [5:0] o_hour, o_min, o_sec;
  logic       o_valid, o_err_pat, o_err_range, o_err_scan;

  typedef struct {
    int h;
    int m;
    int s;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_chk;
  int   n_fail;

  display_scan_decoder #(.SETTLE(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .scan_en    (scan_en),
    .scan_seg   (scan_seg),
    .clr_err    (clr_err),
    .o_hour     (o_hour),
    .o_min      (o_min),
    .o_sec      (o_sec),
    .o_valid    (o_valid),
    .o_err_pat  (o_err_pat),
    .o_err_range(o_err_range),
    .o_err_scan (o_err_scan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  task automatic chk_time(input string nm, input int h, input int m,
                          input int s);
    chk({nm, "_hour"}, int'(o_hour), h);
    chk({nm, "_min"},  int'(o_min),  m);
    chk({nm, "_sec"},  int'(o_sec),  s);
  endtask

  task automatic chk_err(input string nm, input int p, input int r,
                         input int s);
    chk({nm, "_err_pat"},   int'(o_err_pat),   p);
    chk({nm, "_err_range"}, int'(o_err_range), r);
    chk({nm, "_err_scan"},  int'(o_err_scan),  s);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && o_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got o_valid=1 expected 0 (t=%0t)",
                 $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk_time("valid", e.h, e.m, e.s);
      end
    end
  end

  function automatic logic [47:0] pk(
    input logic [7:0] d5, input logic [7:0] d4, input logic [7:0] d3,
    input logic [7:0] d2, input logic [7:0] d1, input logic [7:0] d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Called at a negedge; digit i is held for its dwell in negedges.
  task automatic frame(input logic [47:0] segs, input int dw,
                       input int first, input int last,
                       input int sp_idx, input int sp_dw,
                       input bit expv, input int eh, input int em,
                       input int es);
    for (int i = first; i <= last; i++) begin
      int n;
      n = (i == sp_idx) ? sp_dw : dw;
      if (i == 5 && expv) begin
        exp_t e;
        e.h   = eh;
        e.m   = em;
        e.s   = es;
        e.cyc = cyc + SETTLE;
        q.push_back(e);
      end
      scan_en  = ENS[i];
      scan_seg = segs[8*i +: 8];
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    scan_en  = 8'hFF;
    scan_seg = 8'hFF;
    clr_err  = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk_time("rst", 0, 0, 0);
    chk_err("rst", 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    frame(pk(P1, P2, P3, P4, P5, P6), DW, 0, 5, -1, 0, 1'b1, 12, 34, 56);
    chk_time("f1234", 12, 34, 56);
    chk_err("f1234", 0, 0, 0);

    frame(pk(P0, P1, P0, P2, P0, P3), DS, 0, 5, 3, SETTLE - 1,
          1'b0, 0, 0, 0);
    chk_time("short_dwell", 12, 34, 56);

    frame(pk(P2, P3, P5, P9, P5, P9), DS, 0, 5, 2, SETTLE,
          1'b1, 23, 59, 59);
    chk_time("f2359", 23, 59, 59);

    frame(pk(8'hFF, P2, P3, P4, P5, P6), DS, 0, 5, -1, 0,
          1'b0, 0, 0, 0);
    chk("badpat_set", int'(o_err_pat), 1);
    chk_time("badpat", 23, 59, 59);
    pulse_clr();
    chk("badpat_clr", int'(o_err_pat), 0);

    frame(pk(P0, 8'h78, 8'h40, 8'h00, P0, 8'h10), DS, 0, 5, -1, 0,
          1'b1, 7, 8, 9);
    chk_time("dp_ign", 7, 8, 9);

    frame(pk(P1, P2, P3, P4, P5, P6), DS, 0, 5, -1, 0, 1'b1, 12, 34, 56);
    frame(pk(P2, P9, P0, P0, P0, P0), DS, 0, 5, -1, 0, 1'b0, 0, 0, 0);
    chk("range_set", int'(o_err_range), 1);
    chk_time("range_hold", 12, 34, 56);

    scan_en = 8'hFC;
    clr_err = 1'b1;
    @(negedge clk);
    scan_en = 8'hFF;
    clr_err = 1'b0;
    chk("scan_vs_clr", int'(o_err_scan), 1);
    chk("range_clr", int'(o_err_range), 0);
    pulse_clr();
    chk("scan_clr", int'(o_err_scan), 0);
    scan_en = 8'hFC;
    @(negedge clk);
    scan_en = 8'hFF;
    chk("scan_set", int'(o_err_scan), 1);
    pulse_clr();
    scan_en  = 8'hBF;
    scan_seg = P8;
    repeat (40) @(negedge clk);
    scan_en  = 8'h7F;
    repeat (40) @(negedge clk);
    scan_en  = 8'hFF;
    @(negedge clk);
    chk_err("idle_bits", 0, 0, 0);

    frame(pk(P0, P1, P0, P2, P0, P3), DS, 0, 3, -1, 0, 1'b0, 0, 0, 0);
    scan_en = 8'hFF;
    reset   = 1'b0;
    repeat (2) @(negedge clk);
    chk_time("rst2", 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    frame(pk(P0, P1, P0, P2, P0, P3), DS, 4, 5, -1, 0, 1'b0, 0, 0, 0);
    chk_time("partial", 0, 0, 0);
    frame(pk(P0, P1, P0, P2, P0, P3), DS, 0, 5, -1, 0, 1'b1, 1, 2, 3);
    chk_time("after_rst", 1, 2, 3);

    scan_en = 8'hFF;
    repeat (SETTLE + 4) @(negedge clk);
    chk("pending", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
